// File: rtl/pe_bf_addsub_lanes_pkg.sv
// Shared defaults, control-pipeline payload and helpers for the multi-lane butterfly PE.
// PE_INTT_HALVE_EN folds the INTT 2^-1 scaling into stage 3 when defined.
package pe_bf_addsub_lanes_pkg;

    localparam int unsigned DW_DEF    = 12;
    localparam int unsigned Q_DEF     = 3329;
    localparam int unsigned LANES_DEF = 4;
    localparam int unsigned PIPE_DEF  = 3;

`ifdef PE_INTT_HALVE_EN
    localparam bit HALVE_EN = 1'b1;
`else
    localparam bit HALVE_EN = 1'b0;
`endif

    // Per-stage control payload travelling alongside the lane data.
    typedef struct packed {
        logic vld;
        logic sel;
    } ctl_t;

    // (x+Q)>>1 for odd x equals (x>>1) + (Q+1)/2.
    function automatic int unsigned half_q_adj(input int unsigned q);
        return (q + 1) / 2;
    endfunction

endpackage

// File: rtl/pe_bf_addsub_lanes_lane.sv
// One lane of the butterfly: registered operands, modular add/sub, optional INTT halving,
// then PIPE-3 delay stages. All registers advance only when en_i is high.
module pe_bf_lane
    import pe_bf_addsub_lanes_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned Q    = Q_DEF,
    parameter int unsigned PIPE = PIPE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          sel2_i,
    input  logic [DW-1:0] u_i,
    input  logic [DW-1:0] v_i,
    output logic [DW-1:0] upper_o,
    output logic [DW-1:0] lower_o
);

    localparam int unsigned NDLY   = PIPE - 2;
    localparam logic [DW:0] Q_W    = (DW + 1)'(Q);
    localparam logic [DW-1:0] HALF_Q = DW'(half_q_adj(Q));

    logic [DW-1:0] u1_q, v1_q;
    logic [DW-1:0] s2_q, d2_q, s2_d, d2_d;
    logic [DW-1:0] s3_d, d3_d;
    logic [DW:0]   sum_c, dif_c;
    logic [DW-1:0] up_q [NDLY];
    logic [DW-1:0] lo_q [NDLY];

    function automatic logic [DW-1:0] halve(input logic [DW-1:0] x);
        return x[0] ? ((x >> 1) + HALF_Q) : (x >> 1);
    endfunction

    // Stage 2 modular add/sub and stage 3 optional halving.
    always_comb begin
        sum_c = {1'b0, u1_q} + {1'b0, v1_q};
        dif_c = {1'b0, u1_q} - {1'b0, v1_q};
        s2_d  = (sum_c >= Q_W) ? DW'(sum_c - Q_W) : sum_c[DW-1:0];
        d2_d  = dif_c[DW] ? DW'(dif_c + Q_W) : dif_c[DW-1:0];
        s3_d  = s2_q;
        d3_d  = d2_q;
        if (HALVE_EN && sel2_i) begin
            s3_d = halve(s2_q);
            d3_d = halve(d2_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u1_q <= '0;
            v1_q <= '0;
            s2_q <= '0;
            d2_q <= '0;
            for (int i = 0; i < int'(NDLY); i++) begin
                up_q[i] <= '0;
                lo_q[i] <= '0;
            end
        end else if (en_i) begin
            u1_q    <= u_i;
            v1_q    <= v_i;
            s2_q    <= s2_d;
            d2_q    <= d2_d;
            up_q[0] <= s3_d;
            lo_q[0] <= d3_d;
            for (int i = 1; i < int'(NDLY); i++) begin
                up_q[i] <= up_q[i-1];
                lo_q[i] <= lo_q[i-1];
            end
        end
    end

    assign upper_o = up_q[NDLY-1];
    assign lower_o = lo_q[NDLY-1];

endmodule

// File: rtl/pe_bf_addsub_lanes.sv
// LANES-wide modular add/sub butterfly PE with valid/ready and whole-pipeline stall.
// Build with PE_INTT_HALVE_EN to scale INTT results by 2^-1 mod Q.
module pe_bf_addsub_lanes
    import pe_bf_addsub_lanes_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned Q     = Q_DEF,
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned PIPE  = PIPE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sel,
    input  logic [LANES*DW-1:0] u,
    input  logic [LANES*DW-1:0] v,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] bf_upper,
    output logic [LANES*DW-1:0] bf_lower,
    output logic                out_sel,
    output logic                busy
);

    ctl_t ctl_q [PIPE];
    logic adv_c;

    assign out_valid = ctl_q[PIPE-1].vld;
    assign out_sel   = ctl_q[PIPE-1].sel;
    assign adv_c     = !out_valid | out_ready;
    assign in_ready  = adv_c;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < int'(PIPE); i++) begin
            busy = busy | ctl_q[i].vld;
        end
    end

    // Valid/sel shift register; a bubble enters when in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PIPE); i++) begin
                ctl_q[i] <= '0;
            end
        end else if (adv_c) begin
            ctl_q[0] <= ctl_t'{vld: in_valid, sel: sel};
            for (int i = 1; i < int'(PIPE); i++) begin
                ctl_q[i] <= ctl_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        pe_bf_lane #(
            .DW  (DW),
            .Q   (Q),
            .PIPE(PIPE)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en_i   (adv_c),
            .sel2_i (ctl_q[1].sel),
            .u_i    (u[k*DW +: DW]),
            .v_i    (v[k*DW +: DW]),
            .upper_o(bf_upper[k*DW +: DW]),
            .lower_o(bf_lower[k*DW +: DW])
        );
    end

endmodule

// File: tb/tb_pe_bf_addsub_lanes.sv
// Scoreboard bench for pe_bf_addsub_lanes (LANES=4, DW=12, Q=3329, PIPE=3).
module tb_pe_bf_addsub_lanes;

    localparam int unsigned DW    = 12;
    localparam int unsigned LANES = 4;
    localparam int unsigned PIPE  = 3;
    localparam int unsigned Q     = 3329;
    localparam int unsigned W     = LANES * DW;

`ifdef PE_INTT_HALVE_EN
    localparam bit HALVE = 1'b1;
`else
    localparam bit HALVE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         sel;
    logic [W-1:0] u;
    logic [W-1:0] v;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] bf_upper;
    logic [W-1:0] bf_lower;
    logic         out_sel;
    logic         busy;

    pe_bf_addsub_lanes #(.DW(DW), .Q(Q), .LANES(LANES), .PIPE(PIPE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .u(u), .v(v), .out_valid(out_valid), .out_ready(out_ready),
        .bf_upper(bf_upper), .bf_lower(bf_lower), .out_sel(out_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed vectors: operands, NTT results, halved INTT results.
    int tu [8] = '{3000, 0,    3328, 0,    0, 1234, 2000, 1664};
    int tv [8] = '{1000, 1,    3328, 3328, 0, 567,  2500, 1665};
    int tnu[8] = '{671,  1,    3327, 3328, 0, 1801, 1171, 0};
    int tnl[8] = '{2000, 3328, 0,    1,    0, 667,  2829, 3328};
    int thu[8] = '{2000, 1665, 3328, 1664, 0, 2565, 2250, 0};
    int thl[8] = '{1000, 1664, 0,    1665, 0, 1998, 3079, 1664};

    typedef struct {
        logic [W-1:0] up;
        logic [W-1:0] lo;
        logic         sel;
        int           c;
        bit           lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every delivered beat is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: actual upper=%0h, required no beat", bf_upper);
            end else begin
                mon_e = exp_q.pop_front();
                check("bf_upper", 48'(bf_upper), 48'(mon_e.up));
                check("bf_lower", 48'(bf_lower), 48'(mon_e.lo));
                check("out_sel", 48'(out_sel), 48'(mon_e.sel));
                if (mon_e.lat) check("latency", 48'(cyc - mon_e.c), 48'(PIPE));
            end
        end
    end

    task automatic send(input int i0, input int i1, input int i2, input int i3,
                        input bit s, input bit lat);
        int   idx[4];
        exp_t e;
        bit   acc;
        int   tries;
        idx = '{i0, i1, i2, i3};
        for (int k = 0; k < int'(LANES); k++) begin
            u[k*DW +: DW]    = DW'(tu[idx[k]]);
            v[k*DW +: DW]    = DW'(tv[idx[k]]);
            e.up[k*DW +: DW] = DW'((s && HALVE) ? thu[idx[k]] : tnu[idx[k]]);
            e.lo[k*DW +: DW] = DW'((s && HALVE) ? thl[idx[k]] : tnl[idx[k]]);
        end
        e.sel    = s;
        e.lat    = lat;
        e.c      = 0;
        sel      = s;
        in_valid = 1'b1;
        acc      = 1'b0;
        tries    = 0;
        while (!acc && tries < 100) begin
            @(negedge clk);
            acc = in_ready;
            e.c = cyc;
            @(posedge clk);
            #1;
            tries++;
        end
        if (acc) exp_q.push_back(e);
        else check("accept_timeout", 48'(acc), 48'(1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_pending", 48'(exp_q.size()), 48'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = 1'b0;
        u         = '0;
        v         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 48'(out_valid), 48'(0));
        check("rst_busy", 48'(busy), 48'(0));
        check("rst_in_ready", 48'(in_ready), 48'(1));
        check("rst_bf_upper", 48'(bf_upper), 48'(0));
        check("rst_bf_lower", 48'(bf_lower), 48'(0));
        check("rst_out_sel", 48'(out_sel), 48'(0));
        rst = 1'b0;

        // Single NTT beat, lane 0 only.
        send(0, 4, 4, 4, 1'b0, 1'b1);
        check("busy_inflight", 48'(busy), 48'(1));
        idle();
        drain();

        // INTT beats: result depends on the halving build.
        send(1, 4, 4, 4, 1'b1, 1'b1);
        send(0, 4, 4, 4, 1'b1, 1'b1);
        idle();
        drain();

        // Boundary operands in both modes across lanes.
        send(2, 3, 7, 4, 1'b0, 1'b1);
        send(3, 2, 4, 7, 1'b1, 1'b1);
        idle();
        drain();

        // Back-to-back mixed-mode stream; latency check implies continuous out_valid.
        for (int j = 0; j < 40; j++) begin
            send(j % 8, (j + 3) % 8, (j + 5) % 8, (j + 6) % 8, 1'(j % 2), 1'b1);
        end
        idle();
        drain();

        // Backpressure: downstream stalls for 5 cycles mid-stream.
        fork
            begin
                for (int j = 0; j < 16; j++) begin
                    send((j + 1) % 8, (j + 2) % 8, (j + 4) % 8, (j + 7) % 8, 1'(j % 2), 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", 48'(in_ready), 48'(0));
                    check("stall_out_valid", 48'(out_valid), 48'(1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Reset with three beats in flight, then an immediate post-reset beat.
        send(0, 1, 2, 3, 1'b0, 1'b1);
        send(5, 6, 7, 0, 1'b1, 1'b1);
        send(1, 1, 1, 1, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("mid_rst_out_valid", 48'(out_valid), 48'(0));
        check("mid_rst_busy", 48'(busy), 48'(0));
        check("mid_rst_in_ready", 48'(in_ready), 48'(1));
        rst = 1'b0;
        send(6, 7, 0, 1, 1'b1, 1'b1);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
